// File: rtl/lzc_feeder.sv
// Serializes one operand MSB-chunk-first into the leading-zero counter and returns its answer
// (or a watchdog error) on a valid/ready port. Define LZC_FEEDER_SKID_EN for a one-operand pending register.
`timescale 1ns/1ps
module lzc_feeder #(
    parameter int width   = 4,
    parameter int word    = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [width*word-1:0]   IN_DATA,
    output logic                    MODE,
    output logic                    IVALID,
    output logic [width-1:0]        DATA,
    input  logic                    LZC_OVALID,
    input  logic [5:0]              LZC_ZEROS,
    output logic                    RES_VALID,
    input  logic                    RES_READY,
    output logic [5:0]              RES_ZEROS,
    output logic                    RES_ERR
);
    localparam int W  = width * word;
    localparam int CW = (word > 1) ? $clog2(word) : 1;

    typedef enum logic [1:0] {IDLE, SEND, WAIT, HOLD} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      wd_q, wd_d;
    logic [5:0]      zeros_q, zeros_d;
    logic            err_q, err_d;
    logic            accept;

`ifdef LZC_FEEDER_SKID_EN
    logic            pend_valid_q, pend_valid_d;
    logic [W-1:0]    pend_q, pend_d;

    // Ready is held low during reset so nothing is accepted while the block is being cleared.
    assign IN_READY = ~RST & ((state_q == IDLE) | ~pend_valid_q);
`else
    assign IN_READY = ~RST & (state_q == IDLE);
`endif
    assign accept = IN_VALID & IN_READY;

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        zeros_d = zeros_q;
        err_d   = err_q;
`ifdef LZC_FEEDER_SKID_EN
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        // A busy-time accept parks in the pending register, except on the HOLD
        // handshake cycle where it goes straight into the shift register.
        if (accept && state_q != IDLE && !(state_q == HOLD && RES_READY)) begin
            pend_valid_d = 1'b1;
            pend_d       = IN_DATA;
        end
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = IN_DATA;
                    cnt_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                shift_d = shift_q << width;
                if (cnt_q == CW'(word - 1)) begin
                    state_d = WAIT;
                    wd_d    = 8'(TIMEOUT);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (LZC_OVALID) begin
                    zeros_d = LZC_ZEROS;
                    err_d   = 1'b0;
                    state_d = HOLD;
                end else begin
                    wd_d = wd_q - 8'd1;
                    if (wd_q <= 8'd1) begin
                        zeros_d = '0;
                        err_d   = 1'b1;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (RES_READY) begin
                    state_d = IDLE;
`ifdef LZC_FEEDER_SKID_EN
                    if (pend_valid_q) begin
                        shift_d      = pend_q;
                        pend_valid_d = 1'b0;
                        cnt_d        = '0;
                        state_d      = SEND;
                    end else if (accept) begin
                        shift_d = IN_DATA;
                        cnt_d   = '0;
                        state_d = SEND;
                    end
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            zeros_q <= '0;
            err_q   <= 1'b0;
`ifdef LZC_FEEDER_SKID_EN
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            zeros_q <= zeros_d;
            err_q   <= err_d;
`ifdef LZC_FEEDER_SKID_EN
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
`endif
        end
    end

    assign IVALID    = (state_q == SEND);
    assign MODE      = IVALID && (cnt_q == '0);
    assign DATA      = IVALID ? shift_q[W-1 -: width] : '0;
    assign RES_VALID = (state_q == HOLD);
    assign RES_ZEROS = zeros_q;
    assign RES_ERR   = err_q;
endmodule

// File: tb/tb_lzc_feeder.sv
// Bench for lzc_feeder: table of directed operands, random operands against a leading-zero
// model, plus reset-abort and (with LZC_FEEDER_SKID_EN) pending-operand sequences.
`timescale 1ns/1ps
module tb_lzc_feeder;
    localparam int WIDTH = 4;
    localparam int WORD  = 8;
    localparam int TMO   = 16;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_DATA;
    logic        MODE, IVALID;
    logic [3:0]  DATA;
    logic        LZC_OVALID;
    logic [5:0]  LZC_ZEROS;
    logic        RES_VALID, RES_READY;
    logic [5:0]  RES_ZEROS;
    logic        RES_ERR;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 CLK = ~CLK;

    lzc_feeder #(.width(WIDTH), .word(WORD), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA),
        .MODE(MODE), .IVALID(IVALID), .DATA(DATA), .LZC_OVALID(LZC_OVALID), .LZC_ZEROS(LZC_ZEROS),
        .RES_VALID(RES_VALID), .RES_READY(RES_READY), .RES_ZEROS(RES_ZEROS), .RES_ERR(RES_ERR)
    );

    typedef struct {
        logic [31:0] data;
        int          lat;    // cycles after last chunk that the LZC answers; 0 = never
        int          hold;   // cycles RES_READY stays low
        bit          stray;
        logic [5:0]  z;
        bit          e;
        int          rise;   // cycles after last chunk that RES_VALID rises
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int lzc32(input logic [31:0] d);
        for (int b = 31; b >= 0; b--)
            if (d[b]) return 31 - b;
        return 32;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic offer(input logic [31:0] d);
        int n = 0;
        while (!IN_READY && n < 50) begin
            tick();
            n++;
        end
        chk("in_ready_wait", 64'(IN_READY), 64'd1);
        IN_VALID = 1'b1;
        IN_DATA  = d;
        tick();
        IN_VALID = 1'b0;
    endtask

    // Checks chunks first..last; returns positioned in the cycle of chunk 'last'.
    task automatic send_chunks(input logic [31:0] d, input int first, input int last, input bit stray);
        logic [3:0] exp_c;
        for (int i = first; i <= last; i++) begin
            exp_c = 4'((d >> (4 * (WORD - 1 - i))) & 32'hF);
            chk($sformatf("ivalid[%0d]", i), 64'(IVALID), 64'd1);
            chk($sformatf("mode[%0d]", i), 64'(MODE), 64'(i == 0));
            chk($sformatf("data[%0d]", i), 64'(DATA), 64'(exp_c));
`ifndef LZC_FEEDER_SKID_EN
            chk($sformatf("in_ready_send[%0d]", i), 64'(IN_READY), 64'd0);
`endif
            LZC_OVALID = stray && (i == 3);
            LZC_ZEROS  = 6'd5;
            if (i < last) tick();
        end
        LZC_OVALID = 1'b0;
    endtask

    task automatic get_result(input logic [31:0] d, input int lat, input int exp_rise,
                              input logic [5:0] exp_z, input bit exp_e);
        int rise = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                chk("wait_ivalid", 64'(IVALID), 64'd0);
                chk("wait_mode", 64'(MODE), 64'd0);
                chk("wait_data", 64'(DATA), 64'd0);
            end
            if (RES_VALID) begin
                rise = k;
                break;
            end
            LZC_OVALID = (k == lat);
            LZC_ZEROS  = 6'(lzc32(d));
        end
        LZC_OVALID = 1'b0;
        chk("res_rise", 64'(rise), 64'(exp_rise));
        chk("res_zeros", 64'(RES_ZEROS), 64'(exp_z));
        chk("res_err", 64'(RES_ERR), 64'(exp_e));
    endtask

    task automatic release_res(input int hold, input logic [5:0] exp_z, input bit exp_e);
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 64'(RES_VALID), 64'd1);
            chk("hold_zeros", 64'(RES_ZEROS), 64'(exp_z));
            chk("hold_err", 64'(RES_ERR), 64'(exp_e));
`ifndef LZC_FEEDER_SKID_EN
            chk("hold_in_ready", 64'(IN_READY), 64'd0);
`endif
            LZC_OVALID = 1'b1;   // late answers must not overwrite the held result
            LZC_ZEROS  = 6'd42;
            tick();
        end
        LZC_OVALID = 1'b0;
        chk("hs_valid", 64'(RES_VALID), 64'd1);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk("post_hs_valid", 64'(RES_VALID), 64'd0);
    endtask

    task automatic run_op(input vec_t v);
        offer(v.data);
        send_chunks(v.data, 0, WORD - 1, v.stray);
        get_result(v.data, v.lat, v.rise, v.z, v.e);
        release_res(v.hold, v.z, v.e);
        $display("op data=%08h lat=%0d hold=%0d exp_zeros=%0d exp_err=%0d", v.data, v.lat, v.hold, v.z, v.e);
    endtask

    initial begin
        vec_t        v;
        logic [31:0] a, b;
        bit          ok;

        tbl[0] = '{32'h0012_3456,  2, 0, 1'b0, 6'd11, 1'b0,  3};
        tbl[1] = '{32'h0012_3456,  2, 5, 1'b0, 6'd11, 1'b0,  3};
        tbl[2] = '{32'h0012_3456,  0, 0, 1'b0, 6'd0,  1'b1, 17};
        tbl[3] = '{32'h0000_0000,  2, 0, 1'b1, 6'd32, 1'b0,  3};
        tbl[4] = '{32'hFFFF_FFFF,  1, 1, 1'b0, 6'd0,  1'b0,  2};
        tbl[5] = '{32'h0000_0001, 16, 0, 1'b0, 6'd31, 1'b0, 17};
        tbl[6] = '{32'h0000_0001, 17, 2, 1'b0, 6'd0,  1'b1, 17};

        RST = 1'b1; IN_VALID = 1'b0; IN_DATA = '0; LZC_OVALID = 1'b0; LZC_ZEROS = '0; RES_READY = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", 64'(IN_READY), 64'd0);
        chk("rst_mode", 64'(MODE), 64'd0);
        chk("rst_ivalid", 64'(IVALID), 64'd0);
        chk("rst_data", 64'(DATA), 64'd0);
        chk("rst_res_valid", 64'(RES_VALID), 64'd0);
        chk("rst_res_zeros", 64'(RES_ZEROS), 64'd0);
        chk("rst_res_err", 64'(RES_ERR), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("post_rst_in_ready", 64'(IN_READY), 64'd1);

        for (int t = 0; t < 7; t++) run_op(tbl[t]);

        for (int r = 0; r < 20; r++) begin
            v.data  = $urandom() >> $urandom_range(0, 32);
            v.lat   = $urandom_range(0, 20);
            v.hold  = $urandom_range(0, 3);
            v.stray = 1'($urandom_range(0, 1));
            ok      = (v.lat >= 1) && (v.lat <= TMO);
            v.z     = ok ? 6'(lzc32(v.data)) : 6'd0;
            v.e     = !ok;
            v.rise  = ok ? v.lat + 1 : TMO + 1;
            run_op(v);
        end

        // Reset during chunk 3 aborts asynchronously; next operand restarts cleanly.
        a = 32'hA5C3_0F11;
        offer(a);
        send_chunks(a, 0, 3, 1'b0);
        RST = 1'b1;
        #1;
        chk("abort_ivalid", 64'(IVALID), 64'd0);
        chk("abort_mode", 64'(MODE), 64'd0);
        chk("abort_data", 64'(DATA), 64'd0);
        chk("abort_in_ready", 64'(IN_READY), 64'd0);
        chk("abort_res_valid", 64'(RES_VALID), 64'd0);
        @(negedge CLK);
        RST = 1'b0;
        tick();
        chk("abort_rel_in_ready", 64'(IN_READY), 64'd1);
        $display("op reset abort during chunk 3 of data=%08h", a);
        v = '{32'h0003_0000, 3, 0, 1'b0, 6'd14, 1'b0, 4};
        run_op(v);

`ifdef LZC_FEEDER_SKID_EN
        a = 32'h0F00_0000;
        b = 32'h0000_7ABC;
        offer(a);
        send_chunks(a, 0, 2, 1'b0);
        chk("skid_ready_send", 64'(IN_READY), 64'd1);
        IN_VALID = 1'b1;
        IN_DATA  = b;
        tick();
        IN_VALID = 1'b0;
        chk("skid_ready_full", 64'(IN_READY), 64'd0);
        send_chunks(a, 3, WORD - 1, 1'b0);
        get_result(a, 2, 3, 6'd4, 1'b0);
        RES_READY = 1'b1;
        tick();
        RES_READY = 1'b0;
        chk("skid_res_valid_drop", 64'(RES_VALID), 64'd0);
        send_chunks(b, 0, WORD - 1, 1'b0);
        get_result(b, 2, 3, 6'd17, 1'b0);
        release_res(0, 6'd17, 1'b0);
        $display("op skid pair a=%08h b=%08h", a, b);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
